pipe_alu_core: RTL

PIPE_ALU_CORE -- requirements
Module: pipe_alu_core

---
 rtl/pipe_alu_pkg.sv | 59 +++++
 rtl/pipe_alu_regfile.sv | 33 +++
 rtl/pipe_alu_core.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pipe_alu_pkg.sv
// Shared opcode encoding, instruction field layout and the per-stage control
// record carried down the pipe_alu_core pipeline.
package pipe_alu_pkg;

  typedef enum logic [5:0] {
    OP_ADD  = 6'b000000,
    OP_SUB  = 6'b000010,
    OP_AND  = 6'b000100,
    OP_OR   = 6'b000101,
    OP_EQ   = 6'b001000,
    OP_NE   = 6'b001001,
    OP_ADDI = 6'b001100
  } opcode_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS1_MSB = 25;
  localparam int RS1_LSB = 21;
  localparam int RS2_MSB = 20;
  localparam int RS2_LSB = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 10;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic        vld;
    logic [5:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [10:0] imm;
    logic        we;
    logic        ill;
  } stage_t;

  function automatic logic op_known(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EQ, OP_NE, OP_ADDI: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // Register fields are masked here so every later compare sees real indices.
  function automatic stage_t decode(input logic [31:0] ins, input logic [4:0] idx_mask);
    stage_t s;
    s     = '0;
    s.vld = 1'b1;
    s.op  = ins[OPC_MSB:OPC_LSB];
    s.rs1 = ins[RS1_MSB:RS1_LSB] & idx_mask;
    s.rs2 = ins[RS2_MSB:RS2_LSB] & idx_mask;
    s.rd  = ins[RD_MSB:RD_LSB] & idx_mask;
    s.imm = ins[IMM_MSB:IMM_LSB];
    s.ill = !op_known(s.op);
    s.we  = !s.ill && (s.rd != 5'd0);
    return s;
  endfunction

endpackage

// File: rtl/pipe_alu_regfile.sv
// Register file: two combinational read ports with write-through, one write
// port, register 0 hardwired to zero.
module pipe_alu_regfile
  import pipe_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(NUM_REGS)-1:0] ra1_i,
  input  logic [$clog2(NUM_REGS)-1:0] ra2_i,
  output logic [DATA_WIDTH-1:0]       rd1_o,
  output logic [DATA_WIDTH-1:0]       rd2_o,
  input  logic                        we_i,
  input  logic [$clog2(NUM_REGS)-1:0] wa_i,
  input  logic [DATA_WIDTH-1:0]       wd_i
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == '0) ? '0 : (we_i && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : (we_i && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];

endmodule

// File: rtl/pipe_alu_core.sv
// Five-stage ALU pipeline (IF, ID, EX, MEM, WB) with full forwarding, a
// result memory written in MEM and a retire counter driven from WB.
module pipe_alu_core
  import pipe_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int RES_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [31:0]                  instr_in,
  output logic                         result_valid,
  output logic [DATA_WIDTH-1:0]        result_out,
  output logic                         result_zero,
  output logic                         illegal_op,
  output logic [$clog2(RES_DEPTH)-1:0] wb_addr,
  input  logic [$clog2(RES_DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [15:0]                  retired_cnt
);

  localparam int         RW       = $clog2(NUM_REGS);
  localparam int         AW       = $clog2(RES_DEPTH);
  localparam logic [4:0] IDX_MASK = 5'(NUM_REGS - 1);

  stage_t                if_q, id_q, ex_q, mem_q;
  logic [DATA_WIDTH-1:0] id_a_q, id_b_q, ex_res_q, mem_res_q;
  logic [DATA_WIDTH-1:0] rf_rd1, rf_rd2, op_a_d, op_b_d, alu_res_d;
  logic [DATA_WIDTH-1:0] res_q, rd_data_q;
  logic [DATA_WIDTH-1:0] rmem_q [RES_DEPTH];
  logic [AW-1:0]         wb_addr_q;
  logic [15:0]           cnt_q;
  logic                  res_vld_q, res_zero_q, res_ill_q;
  logic                  accept, rf_we;
  logic                  unused_bits;

  assign instr_ready = enable;
  assign accept      = instr_valid && enable;
  assign rf_we       = enable && mem_q.vld && mem_q.we;
  assign unused_bits = ^{mem_q.op, mem_q.rs1, mem_q.rs2, mem_q.imm, mem_q.rd};

  pipe_alu_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .ra1_i(if_q.rs1[RW-1:0]),
    .ra2_i(if_q.rs2[RW-1:0]),
    .rd1_o(rf_rd1),
    .rd2_o(rf_rd2),
    .we_i (rf_we),
    .wa_i (mem_q.rd[RW-1:0]),
    .wd_i (mem_res_q)
  );

  // EX operands: youngest producer wins; older writes arrived via write-through.
  always_comb begin
    op_a_d = id_a_q;
    op_b_d = id_b_q;
    if (ex_q.vld && ex_q.we && (ex_q.rd == id_q.rs1))        op_a_d = ex_res_q;
    else if (mem_q.vld && mem_q.we && (mem_q.rd == id_q.rs1)) op_a_d = mem_res_q;
    if (ex_q.vld && ex_q.we && (ex_q.rd == id_q.rs2))        op_b_d = ex_res_q;
    else if (mem_q.vld && mem_q.we && (mem_q.rd == id_q.rs2)) op_b_d = mem_res_q;
  end

  always_comb begin
    alu_res_d = '0;
    case (id_q.op)
      OP_ADD:  alu_res_d = op_a_d + op_b_d;
      OP_SUB:  alu_res_d = op_a_d - op_b_d;
      OP_AND:  alu_res_d = op_a_d & op_b_d;
      OP_OR:   alu_res_d = op_a_d | op_b_d;
      OP_EQ:   alu_res_d = DATA_WIDTH'(op_a_d == op_b_d);
      OP_NE:   alu_res_d = DATA_WIDTH'(op_a_d != op_b_d);
      OP_ADDI: alu_res_d = op_a_d + DATA_WIDTH'(id_q.imm);
      default: alu_res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_q       <= '0;
      id_q       <= '0;
      ex_q       <= '0;
      mem_q      <= '0;
      id_a_q     <= '0;
      id_b_q     <= '0;
      ex_res_q   <= '0;
      mem_res_q  <= '0;
      wb_addr_q  <= '0;
      res_vld_q  <= 1'b0;
      res_q      <= '0;
      res_zero_q <= 1'b0;
      res_ill_q  <= 1'b0;
      cnt_q      <= '0;
    end else if (enable) begin
      // IF: capture or insert a bubble
      if_q      <= accept ? decode(instr_in, IDX_MASK) : '0;
      // ID/EX boundary
      id_q      <= if_q;
      id_a_q    <= rf_rd1;
      id_b_q    <= rf_rd2;
      // EX/MEM boundary
      ex_q      <= id_q;
      ex_res_q  <= alu_res_d;
      // MEM/WB boundary
      mem_q     <= ex_q;
      mem_res_q <= ex_res_q;
      if (ex_q.vld) wb_addr_q <= wb_addr_q + AW'(1);
      // WB: retire
      res_vld_q <= mem_q.vld;
      if (mem_q.vld) begin
        res_q      <= mem_res_q;
        res_zero_q <= (mem_res_q == '0);
        res_ill_q  <= mem_q.ill;
        cnt_q      <= cnt_q + 16'd1;
      end
    end else begin
      res_vld_q <= 1'b0;
    end
  end

  // Result memory is not reset; the read port runs regardless of enable.
  always_ff @(posedge clk) begin
    if (enable && ex_q.vld) rmem_q[wb_addr_q] <= ex_res_q;
    rd_data_q <= rmem_q[rd_addr];
  end

  assign result_valid = res_vld_q;
  assign result_out   = res_q;
  assign result_zero  = res_zero_q;
  assign illegal_op   = res_ill_q;
  assign wb_addr      = wb_addr_q;
  assign rd_data      = rd_data_q;
  assign retired_cnt  = cnt_q;

endmodule
